video_stream_gen: RTL and testbench
===================================

Name: video_stream_gen

Overview:
- Frame/line timing transmitter that drives the vsync/hsync/data video stream consumed by the Sobel kernel and line-buffer blocks.
- Produces programmable frame timing and emits pixels from an external pixel source (request/response) or an internal test pattern.
- Used as the stimulus source in simulation platforms and as the on-chip test-pattern source ahead of the edge-detect chain.

Parameters:
- DW, 8: pixel data width.
- IW, 4: active pixels per line; must be ≥1.
- IH, 3: active lines per frame; must be ≥1.
- H_TOTAL, 8: cycles per line, active plus blank; must be > IW.
- V_LEAD, 6: cycles from the dout_vsync rise to the first dout_hsync rise; must be ≥1.
- V_GAP, 15: cycles dout_vsync stays low between frames in continuous mode; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; starts one frame when idle.
- continuous  in  1  when high, frames repeat back-to-back.
- mode  in  2  data source: 0 external pix_din, 1 x ramp, 2 y ramp, 3 x+y ramp.
- pix_din  in  DW  external pixel value, sampled on the edge ending a pix_req cycle.
- pix_req  out  1  external pixel request, one cycle ahead of the matching dout pixel.
- pix_x  out  16  column index of the requested pixel, valid while pix_req is high.
- pix_y  out  16  line index of the requested pixel, valid while pix_req is high.
- dout_vsync  out  1  frame valid.
- dout_hsync  out  1  line valid; pixel qualifier.
- dout  out  DW  pixel data, synchronous with dout_hsync.
- busy  out  1  high from the start acceptance edge until the FSM returns to IDLE.
- frame_done  out  1  one-cycle pulse in the cycle dout_vsync falls.

Behaviour:
- Reset (asynchronous, any time, including mid-line): all outputs go to 0, FSM goes to IDLE, all counters clear, the latched mode clears to 0.
- FSM states: IDLE, LEAD, ACTIVE, HBLANK, GAP.
  - IDLE: start=1 moves to LEAD and latches mode. start is ignored in every other state.
  - LEAD: V_LEAD cycles, dout_vsync=1, then ACTIVE with y=0.
  - ACTIVE: IW cycles with dout_hsync=1; x runs 0..IW-1. Then HBLANK.
  - HBLANK: H_TOTAL-IW cycles with dout_hsync=0.
    - If y<IH-1: y increments, go to ACTIVE.
    - Otherwise: dout_vsync falls and frame_done pulses. If continuous=1, go to GAP; else go to IDLE and busy drops.
  - GAP: V_GAP cycles with dout_vsync=0, then LEAD, re-latching mode. continuous is sampled at GAP exit: if low, go to IDLE instead.
- Timing:
  - All stream outputs are registered.
  - dout_vsync rises on the edge after start is accepted.
  - dout_vsync high time is V_LEAD + IH·H_TOTAL cycles.
  - Frame period in continuous mode is V_LEAD + IH·H_TOTAL + V_GAP cycles (45 with the defaults).
- Pixel handshake:
  - pix_req is high in cycle t exactly when cycle t+1 is an ACTIVE cycle.
  - pix_x/pix_y carry that pixel's coordinates.
  - dout(t+1) = pix_din sampled at the end of cycle t.
  - No backpressure: the source must return data every request cycle.
  - pix_req toggles in modes 1–3 too; pix_din is ignored in those modes.
- Pattern arithmetic:
  - x and y are the 16-bit counters; dout = x, y, or x+y truncated to DW bits (modulo 2^DW).
  - dout is 0 whenever dout_hsync=0.
- mode changes mid-frame have no effect until the next latch.
- continuous deasserted mid-frame: the current frame completes normally.
- Edge case: start and continuous both high in IDLE starts free-running.

Decomposition:
- Shared package/header video_gen_pkg holds:
  - FSM state encodings.
  - Mode constants MODE_EXT=0, MODE_XRAMP=1, MODE_YRAMP=2, MODE_XYRAMP=3.
  - Counter width CW=16.
- Sub-module video_pattern_gen, registered: takes the latched mode, x, y and pix_din and produces dout one cycle after the request. The FSM and counters stay in the top module.

Test Plan:
- Mode 0, defaults, single start, source returns 10,8,15,39 / 43,37,7,2 / 80,62,12,26 in request order.
  - Required: dout_vsync high for 30 cycles.
  - Required: first dout_hsync rises 6 cycles after dout_vsync rises.
  - Required: three lines of 4 cycles high and 4 low, carrying those values.
  - Required: frame_done pulses once, then busy=0.
- Mode 1, IW=4: each line dout=0,1,2,3. Mode 3, line 2: dout=2,3,4,5. Mode 1 with IW=300, DW=8: column 256 outputs 0 (wrap).
- continuous=1 for two frames:
  - Required: dout_vsync rises at cycles 1 and 46, i.e. a 45-cycle period.
  - Required: exactly one frame_done per frame.
  - Drop continuous in frame 2: after frame 2 the FSM is IDLE with no third vsync.
- start pulses in LEAD, in ACTIVE and in GAP: no timing change and no extra frame.
- Assert rst during the 2nd pixel of line 1: all outputs are 0 immediately, without waiting for a clock edge. Next start produces a clean full frame starting at x=0, y=0.
- Change mode from 1 to 2 mid-frame: the current frame stays x ramp; the next frame is y ramp, dout=0,0,0,0 / 1,1,1,1 / 2,2,2,2.

Source files
------------

// File: rtl/video_gen_pkg.sv
// Shared definitions for the video stream generator: FSM states, source modes, counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_gen_pkg;

  // Width of the x/y/phase counters and of the pixel coordinate outputs
  localparam int CW = 16;

  // Pixel data source selection
  localparam logic [1:0] MODE_EXT    = 2'd0;
  localparam logic [1:0] MODE_XRAMP  = 2'd1;
  localparam logic [1:0] MODE_YRAMP  = 2'd2;
  localparam logic [1:0] MODE_XYRAMP = 2'd3;

  // Frame timing phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    GAP    = 3'd4
  } state_t;

endpackage

// File: rtl/video_pattern_gen.sv
// Pixel value stage: picks external data or an x/y ramp and registers it onto dout.
// Latency: 1 cycle from the request cycle to the matching dout pixel.
// Backpressure: none; every request cycle produces a pixel, non-request cycles force 0.
module video_pattern_gen
  import video_gen_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          req,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [DW-1:0] pix_din,
  output logic [DW-1:0] dout
);

  logic [CW-1:0] sum;
  logic [DW-1:0] pat;

  // Select the pixel value for the requested coordinate; ramps wrap modulo 2^DW
  always_comb begin
    sum = x + y;
    pat = pix_din;
    case (mode)
      MODE_XRAMP:  pat = DW'(x);
      MODE_YRAMP:  pat = DW'(y);
      MODE_XYRAMP: pat = DW'(sum);
      default:     pat = pix_din;
    endcase
  end

  // Register the pixel; outside a request the line is blank so dout is held at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= req ? pat : '0;
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Frame/line timing transmitter producing vsync/hsync/dout from an external source or test pattern.
// Latency: vsync rises on the edge accepting start; pix_req leads its dout pixel by 1 cycle.
// Backpressure: none; the pixel source must answer every pix_req cycle.
module video_stream_gen
  import video_gen_pkg::*;
#(
  parameter int DW      = 8,
  parameter int IW      = 4,
  parameter int IH      = 3,
  parameter int H_TOTAL = 8,
  parameter int V_LEAD  = 6,
  parameter int V_GAP   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] pix_din,
  output logic          pix_req,
  output logic [15:0]   pix_x,
  output logic [15:0]   pix_y,
  output logic          dout_vsync,
  output logic          dout_hsync,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          frame_done
);

  // Terminal counts of each phase, counted from 0
  localparam logic [CW-1:0] LEAD_LAST = CW'(V_LEAD - 1);
  localparam logic [CW-1:0] ACT_LAST  = CW'(IW - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(H_TOTAL - IW - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(V_GAP - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(IH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] y, y_nxt;
  logic [1:0]    mode_lat, mode_nxt;
  logic          frame_end;
  logic          req_nxt;
  logic [CW-1:0] px_nxt, py_nxt;

  // Phase sequencing: cnt counts cycles within the current phase, in ACTIVE it is the column
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    y_nxt     = y;
    mode_nxt  = mode_lat;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = LEAD;
          mode_nxt  = mode;
        end
      end
      LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          y_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (cnt == ACT_LAST) begin
          state_nxt = HBLANK;
          cnt_nxt   = '0;
        end
      end
      HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_nxt = '0;
          if (y != Y_LAST) begin
            y_nxt     = y + CW'(1);
            state_nxt = ACTIVE;
          end else begin
            frame_end = 1'b1;
            state_nxt = continuous ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (continuous) begin
            state_nxt = LEAD;
            mode_nxt  = mode;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Look one phase step past state_nxt so pix_req can be registered yet still lead its pixel
  always_comb begin
    req_nxt = 1'b0;
    px_nxt  = '0;
    py_nxt  = '0;
    case (state_nxt)
      LEAD: begin
        if (cnt_nxt == LEAD_LAST) begin
          req_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_nxt != ACT_LAST) begin
          req_nxt = 1'b1;
          px_nxt  = cnt_nxt + CW'(1);
          py_nxt  = y_nxt;
        end
      end
      HBLANK: begin
        if ((cnt_nxt == HB_LAST) && (y_nxt != Y_LAST)) begin
          req_nxt = 1'b1;
          py_nxt  = y_nxt + CW'(1);
        end
      end
      default: begin
        req_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered stream/handshake outputs decoded from the next phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      y          <= '0;
      mode_lat   <= MODE_EXT;
      dout_vsync <= 1'b0;
      dout_hsync <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_req    <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      y          <= y_nxt;
      mode_lat   <= mode_nxt;
      dout_vsync <= (state_nxt == LEAD) || (state_nxt == ACTIVE) || (state_nxt == HBLANK);
      dout_hsync <= (state_nxt == ACTIVE);
      busy       <= (state_nxt != IDLE);
      frame_done <= frame_end;
      pix_req    <= req_nxt;
      pix_x      <= px_nxt;
      pix_y      <= py_nxt;
    end
  end

  video_pattern_gen #(
    .DW(DW)
  ) u_pattern (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode_lat),
    .req    (pix_req),
    .x      (pix_x),
    .y      (pix_y),
    .pix_din(pix_din),
    .dout   (dout)
  );

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: frame-offset reference model compared every cycle, plus literal timing/data pins.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_video_stream_gen;

  localparam int DW  = 8;
  localparam int IW  = 4;
  localparam int IH  = 3;
  localparam int HT  = 8;
  localparam int VL  = 6;
  localparam int VG  = 15;
  localparam int FL  = VL + IH * HT;   // vsync high time
  localparam int PER = FL + VG;        // continuous frame period

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] pix_din = '0;
  logic          pix_req;
  logic [15:0]   pix_x, pix_y;
  logic          dout_vsync, dout_hsync;
  logic [DW-1:0] dout;
  logic          busy, frame_done;

  logic          start_w = 1'b0;
  logic          w_req, w_vs, w_hs, w_busy, w_fd;
  logic [15:0]   w_x, w_y;
  logic [7:0]    w_dout;

  always #5 clk = ~clk;

  video_stream_gen #(.DW(DW), .IW(IW), .IH(IH), .H_TOTAL(HT), .V_LEAD(VL), .V_GAP(VG)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
    .pix_din(pix_din), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .dout_vsync(dout_vsync), .dout_hsync(dout_hsync), .dout(dout),
    .busy(busy), .frame_done(frame_done)
  );

  // Wide-line instance for the 8-bit ramp wrap at column 256
  video_stream_gen #(.DW(8), .IW(300), .IH(1), .H_TOTAL(304), .V_LEAD(6), .V_GAP(15)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .continuous(1'b0), .mode(2'd1),
    .pix_din(8'd0), .pix_req(w_req), .pix_x(w_x), .pix_y(w_y),
    .dout_vsync(w_vs), .dout_hsync(w_hs), .dout(w_dout),
    .busy(w_busy), .frame_done(w_fd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one offset counter into the frame period
  bit         m_busy = 0;
  bit         m_fd = 0;
  int         m_k = 0;
  logic [1:0] m_mode = 2'd0;
  logic [7:0] m_din = 8'd0;

  // Directed source table
  bit   use_tbl = 0;
  int   tbl_idx = 0;
  int   tbl[12] = '{10, 8, 15, 39, 43, 37, 7, 2, 80, 62, 12, 26};

  // Event records
  int vs_rise[$];
  int vs_len[$];
  int hs_rise[$];
  int cap[$];
  int wcap[$];
  int fd_cnt = 0;
  int vs_cnt = 0;
  bit p_vs = 0;
  bit p_hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic bit is_act(input int k);
    return (k >= VL) && (k < FL) && (((k - VL) % HT) < IW);
  endfunction

  function automatic int exp_pix(input int k);
    int col, line, v;
    col = (k - VL) % HT;
    line = (k - VL) / HT;
    case (m_mode)
      2'd0:    v = int'(m_din);
      2'd1:    v = col;
      2'd2:    v = line;
      default: v = col + line;
    endcase
    return v % 256;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_fd = 0;
    m_k = 0;
    m_mode = 2'd0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_fd = 0;
      m_din = pix_din;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_k = 0;
          m_mode = mode;
        end
      end else if (m_k == FL - 1) begin
        m_fd = 1;
        if (continuous) m_k++;
        else m_busy = 0;
      end else if (m_k == PER - 1) begin
        if (continuous) begin
          m_k = 0;
          m_mode = mode;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic compare();
    bit e_vs, e_hs, e_req;
    int ed;
    e_vs  = m_busy && (m_k < FL);
    e_hs  = m_busy && is_act(m_k);
    e_req = m_busy && is_act(m_k + 1);
    ed    = e_hs ? exp_pix(m_k) : 0;
    chk("vsync", dout_vsync, e_vs);
    chk("hsync", dout_hsync, e_hs);
    chk("dout", dout, ed);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_fd);
    chk("pix_req", pix_req, e_req);
    if (e_req) begin
      chk("pix_x", pix_x, (m_k + 1 - VL) % HT);
      chk("pix_y", pix_y, (m_k + 1 - VL) / HT);
    end
    if (dout_vsync && !p_vs) begin
      vs_rise.push_back(cyc);
      vs_cnt = 0;
    end
    if (dout_vsync) vs_cnt++;
    if (!dout_vsync && p_vs) vs_len.push_back(vs_cnt);
    if (dout_hsync && !p_hs) hs_rise.push_back(cyc);
    if (dout_hsync) cap.push_back(int'(dout));
    if (frame_done) fd_cnt++;
    if (w_hs) wcap.push_back(int'(w_dout));
    p_vs = dout_vsync;
    p_hs = dout_hsync;
  endtask

  task automatic drive_din();
    if (use_tbl && m_busy && is_act(m_k + 1)) begin
      pix_din = DW'(tbl[tbl_idx % 12]);
      tbl_idx++;
    end else begin
      pix_din = DW'($urandom);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive inputs just after
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    drive_din();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, dout_vsync, 0);
    chk({tag, "_hsync"}, dout_hsync, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pix_req"}, pix_req, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
  endtask

  initial begin
    int s, b_vr, b_vl, b_hr, b_cap, b_fd;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Mode 0 single frame from the directed table
    use_tbl = 1; tbl_idx = 0; mode = 2'd0;
    b_vr = vs_rise.size(); b_vl = vs_len.size(); b_hr = hs_rise.size(); b_cap = cap.size(); b_fd = fd_cnt;
    s = cyc; start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    use_tbl = 0;
    chk("f1_vs_delay", qat(vs_rise, b_vr) - s, 1);
    chk("f1_vs_len", qat(vs_len, b_vl), 30);
    chk("f1_hs_lead", qat(hs_rise, b_hr) - qat(vs_rise, b_vr), 6);
    chk("f1_lines", hs_rise.size() - b_hr, 3);
    chk("f1_line_pitch", qat(hs_rise, b_hr + 1) - qat(hs_rise, b_hr), 8);
    chk("f1_pixels", cap.size() - b_cap, 12);
    for (int i = 0; i < 12; i++) chk("f1_data", qat(cap, b_cap + i), tbl[i]);
    chk("f1_frame_done", fd_cnt - b_fd, 1);
    chk("f1_busy_end", busy, 0);

    // Mode 1 and mode 3 ramps
    b_cap = cap.size(); mode = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    for (int i = 0; i < 12; i++) chk("xramp", qat(cap, b_cap + i), i % 4);
    b_cap = cap.size(); mode = 2'd3;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    for (int i = 0; i < 4; i++) chk("xyramp_line2", qat(cap, b_cap + 8 + i), 2 + i);

    // Continuous, dropped during frame 2
    mode = 2'd0;
    b_vr = vs_rise.size(); b_vl = vs_len.size(); b_fd = fd_cnt; s = cyc;
    for (int i = 0; i < 120; i++) begin
      start = (i == 0);
      continuous = (i < 57);
      tick();
    end
    chk("cont_first_rise", qat(vs_rise, b_vr) - s, 1);
    chk("cont_period", qat(vs_rise, b_vr + 1) - qat(vs_rise, b_vr), 45);
    chk("cont_rises", vs_rise.size() - b_vr, 2);
    chk("cont_frame2_len", qat(vs_len, b_vl + 1), 30);
    chk("cont_frame_done", fd_cnt - b_fd, 2);
    chk("cont_busy_end", busy, 0);

    // Start pulses in LEAD, ACTIVE and GAP are ignored
    mode = 2'd3;
    b_vr = vs_rise.size(); b_fd = fd_cnt;
    for (int i = 0; i < 110; i++) begin
      start = (i == 0) || (i == 3) || (i == 10) || (i == 37);
      continuous = (i < 51);
      tick();
    end
    chk("ign_period", qat(vs_rise, b_vr + 1) - qat(vs_rise, b_vr), 45);
    chk("ign_rises", vs_rise.size() - b_vr, 2);
    chk("ign_frame_done", fd_cnt - b_fd, 2);

    // Asynchronous reset at line 1, column 1
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      start = (i == 0);
      tick();
    end
    #2;
    chk("pre_rst_hsync", dout_hsync, 1);
    chk("pre_rst_dout", dout, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    b_vr = vs_rise.size(); b_vl = vs_len.size(); b_cap = cap.size(); s = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    chk("post_rst_rise", qat(vs_rise, b_vr) - s, 1);
    chk("post_rst_len", qat(vs_len, b_vl), 30);
    for (int i = 0; i < 12; i++) chk("post_rst_xramp", qat(cap, b_cap + i), i % 4);

    // Mode 1 -> 2 mid-frame takes effect on the next frame
    b_cap = cap.size(); b_vr = vs_rise.size();
    for (int i = 0; i < 110; i++) begin
      start = (i == 0);
      if (i == 20) mode = 2'd2;
      continuous = (i < 60);
      tick();
    end
    for (int i = 0; i < 12; i++) chk("mchg_f1", qat(cap, b_cap + i), i % 4);
    for (int i = 0; i < 12; i++) chk("mchg_f2", qat(cap, b_cap + 12 + i), i / 4);
    chk("mchg_rises", vs_rise.size() - b_vr, 2);

    // Random traffic against the model
    for (int i = 0; i < 900; i++) begin
      start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; continuous = 1'b0;
    repeat (60) tick();

    // 8-bit x ramp wrap on a 300-pixel line
    start_w = 1'b1; tick(); start_w = 1'b0;
    repeat (320) tick();
    chk("wrap_count", wcap.size(), 300);
    chk("wrap_col0", qat(wcap, 0), 0);
    chk("wrap_col255", qat(wcap, 255), 255);
    chk("wrap_col256", qat(wcap, 256), 0);
    chk("wrap_col299", qat(wcap, 299), 43);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
